// File: rtl/ctxt_merge_pkg.sv
// ============================================================================
//  Module   : ctxt_merge_pkg
//  Purpose  : Shared bit positions and arbiter state encoding for the
//             context/data packet merge.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package ctxt_merge_pkg;

   localparam int SOF_BIT = 32;
   localparam int EOF_BIT = 33;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PASS0 = 2'd1;
   localparam logic [1:0] PASS1 = 2'd2;

endpackage

`default_nettype wire

// File: rtl/merge_obuf.sv
// ============================================================================
//  Module   : merge_obuf
//  Purpose  : 2-entry registered output buffer; decouples downstream ready
//             from the input-side ready.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module merge_obuf #(
   parameter int WIDTH = 36
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_src_rdy,
   output logic             o_dst_rdy,
   output logic [WIDTH-1:0] o_data,
   output logic             o_src_rdy,
   input  logic             i_dst_rdy
);

   logic [1:0]       r_count;
   logic [WIDTH-1:0] r_head;
   logic [WIDTH-1:0] r_tail;
   logic             w_wr;
   logic             w_rd;

   // Full comes from the registered count, so a read in the same cycle
   // never opens room for a write.
   assign o_dst_rdy = (r_count != 2'd2);
   assign o_src_rdy = (r_count != 2'd0);
   assign w_wr      = i_src_rdy & o_dst_rdy;
   assign w_rd      = o_src_rdy & i_dst_rdy;
   assign o_data    = r_head;

   always_ff @(posedge clk) begin
      if (reset | clear) begin
         r_count <= 2'd0;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         r_count <= r_count + {1'b0, w_wr} - {1'b0, w_rd};
         if (w_rd && (r_count == 2'd2))
            r_head <= r_tail;
         else if (w_wr && ((r_count == 2'd0) || ((r_count == 2'd1) && w_rd)))
            r_head <= i_data;
         if (w_wr && (r_count == 2'd1) && !w_rd)
            r_tail <= i_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ctxt_data_merge.sv
// ============================================================================
//  Module   : ctxt_data_merge
//  Purpose  : Packet-atomic 2:1 merge of context and sample packets onto one
//             registered output. CTXT_DATA_MERGE_RR_EN selects round-robin
//             arbitration; otherwise the context input has strict priority.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ctxt_data_merge
   import ctxt_merge_pkg::*;
#(
   parameter int WIDTH = 36
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [WIDTH-1:0] ctxt_i,
   input  logic             ctxt_src_rdy_i,
   output logic             ctxt_dst_rdy_o,
   input  logic [WIDTH-1:0] data_i,
   input  logic             data_src_rdy_i,
   output logic             data_dst_rdy_o,
   output logic [WIDTH-1:0] data_o,
   output logic             src_rdy_o,
   input  logic             dst_rdy_i
);

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             w_sel_src;
   logic [WIDTH-1:0] w_sel_data;
   logic             w_buf_rdy;
   logic             w_wr;
   logic             w_pick_ctxt;

`ifdef CTXT_DATA_MERGE_RR_EN
   logic r_last;

   // With both requesting, the input not granted last time wins.
   assign w_pick_ctxt = ctxt_src_rdy_i & (~data_src_rdy_i | r_last);

   always_ff @(posedge clk) begin
      if (reset | clear)
         r_last <= 1'b1;
      else if ((r_state == IDLE) && (w_state_nxt == PASS0))
         r_last <= 1'b0;
      else if ((r_state == IDLE) && (w_state_nxt == PASS1))
         r_last <= 1'b1;
   end
`else
   assign w_pick_ctxt = ctxt_src_rdy_i;
`endif

   always_comb begin
      w_sel_src  = 1'b0;
      w_sel_data = '0;
      case (r_state)
         PASS0: begin
            w_sel_src  = ctxt_src_rdy_i;
            w_sel_data = ctxt_i;
         end
         PASS1: begin
            w_sel_src  = data_src_rdy_i;
            w_sel_data = data_i;
         end
         default: ;
      endcase
   end

   assign ctxt_dst_rdy_o = (r_state == PASS0) & w_buf_rdy;
   assign data_dst_rdy_o = (r_state == PASS1) & w_buf_rdy;
   assign w_wr           = w_sel_src & w_buf_rdy;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_pick_ctxt)
               w_state_nxt = PASS0;
            else if (data_src_rdy_i)
               w_state_nxt = PASS1;
         end
         PASS0, PASS1: begin
            if (w_wr && w_sel_data[EOF_BIT])
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset | clear)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   merge_obuf #(
      .WIDTH(WIDTH)
   ) u_obuf (
      .clk      (clk),
      .reset    (reset),
      .clear    (clear),
      .i_data   (w_sel_data),
      .i_src_rdy(w_sel_src),
      .o_dst_rdy(w_buf_rdy),
      .o_data   (data_o),
      .o_src_rdy(src_rdy_o),
      .i_dst_rdy(dst_rdy_i)
   );

endmodule

`default_nettype wire
